// File: rtl/bullet_pool.sv
// Multi-bullet sprite engine: NB slots spawned over valid/ready, moved every DIV
// frames by a one-slot-per-cycle UPDATE walk, and drawn as circles per pixel.
module bullet_pool #(
  parameter int NB     = 4,
  parameter int RADIUS = 5,
  parameter int DIV    = 2,
  parameter int HIT    = 8,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480
) (
  input  logic          Pclk,
  input  logic          rst_n,
  input  logic [9:0]    xx,
  input  logic [9:0]    yy,
  input  logic          aactive,
  input  logic          spawn_valid,
  output logic          spawn_ready,
  input  logic [9:0]    spawn_x,
  input  logic [9:0]    spawn_y,
  input  logic [3:0]    spawn_dx,
  input  logic [3:0]    spawn_dy,
  input  logic [9:0]    heart_x,
  input  logic [9:0]    heart_y,
  output logic          BulletSpriteOn,
  output logic          hit,
  output logic [NB-1:0] active_mask
);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         divc;
  logic                  rdy_en;
  logic [NB-1:0]         active;
  logic [NB-1:0][9:0]    bx, by;
  logic [NB-1:0][3:0]    bdx, bdy;

  logic                  frame_end, div_wrap, accept, any_free;
  logic [IW-1:0]         free_idx;
  logic signed [11:0]    nx, ny, hdx, hdy;
  logic [11:0]           adx, ady;
  logic                  off_scr, on_heart;
  logic [NB-1:0]         on;

  assign frame_end   = (xx == 10'(H_ACT-1)) && (yy == 10'(V_ACT-1));
  assign div_wrap    = frame_end && (divc == DW'(DIV-1));
  // rdy_en holds ready low for the first cycle out of reset
  assign spawn_ready = rdy_en && (state == IDLE) && any_free;
  assign accept      = spawn_valid && spawn_ready;
  assign active_mask = active;

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NB-1; i >= 0; i--)
      if (!active[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
  end

  // Move/collide math for the slot currently being visited
  always_comb begin
    nx       = $signed({2'b00, bx[idx]}) + $signed({{8{bdx[idx][3]}}, bdx[idx]});
    ny       = $signed({2'b00, by[idx]}) + $signed({{8{bdy[idx][3]}}, bdy[idx]});
    hdx      = nx - $signed({2'b00, heart_x});
    hdy      = ny - $signed({2'b00, heart_y});
    adx      = hdx[11] ? 12'(-hdx) : 12'(hdx);
    ady      = hdy[11] ? 12'(-hdy) : 12'(hdy);
    off_scr  = nx[11] || ny[11] ||
               (nx > $signed(12'(H_ACT-1))) || (ny > $signed(12'(V_ACT-1)));
    on_heart = (adx <= 12'(HIT)) && (ady <= 12'(HIT));
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      divc   <= '0;
      rdy_en <= 1'b0;
      hit    <= 1'b0;
      active <= '0;
      bx     <= '0;
      by     <= '0;
      bdx    <= '0;
      bdy    <= '0;
    end else begin
      rdy_en <= 1'b1;
      hit    <= 1'b0;
      if (frame_end) divc <= div_wrap ? '0 : divc + 1'b1;
      if (accept) begin
        active[free_idx] <= 1'b1;
        bx[free_idx]     <= spawn_x;
        by[free_idx]     <= spawn_y;
        bdx[free_idx]    <= spawn_dx;
        bdy[free_idx]    <= spawn_dy;
      end
      case (state)
        IDLE: if (div_wrap) begin
          state <= UPDATE;
          idx   <= '0;
        end
        UPDATE: begin
          if (active[idx]) begin
            if (off_scr) active[idx] <= 1'b0;
            else if (on_heart) begin
              active[idx] <= 1'b0;
              hit         <= 1'b1;
            end else begin
              bx[idx] <= nx[9:0];
              by[idx] <= ny[9:0];
            end
          end
          if (idx == IW'(NB-1)) state <= IDLE;
          else                  idx   <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-slot circle test; offsets are true signed distances, no screen wrap
  for (genvar i = 0; i < NB; i++) begin : g_pix
    logic signed [21:0] ex, ey;
    logic [22:0]        d2;
    assign ex    = 22'($signed({1'b0, xx}) - $signed({1'b0, bx[i]}));
    assign ey    = 22'($signed({1'b0, yy}) - $signed({1'b0, by[i]}));
    assign d2    = {1'b0, 22'(ex * ex)} + {1'b0, 22'(ey * ey)};
    assign on[i] = active[i] && (d2 <= 23'(RADIUS*RADIUS));
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) BulletSpriteOn <= 1'b0;
    else        BulletSpriteOn <= aactive && (|on);
  end
endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios plus a randomized run, all checked
// against a slot-list model that applies the move/despawn/draw rules directly.
module tb_bullet_pool;
  localparam int NB = 4;
  localparam int DIV = 2;

  logic          Pclk = 1'b0;
  logic          rst_n;
  logic [9:0]    xx, yy, spawn_x, spawn_y, heart_x, heart_y;
  logic          aactive, spawn_valid;
  logic [3:0]    spawn_dx, spawn_dy;
  logic          spawn_ready, BulletSpriteOn, hit;
  logic [NB-1:0] active_mask;

  int checks = 0;
  int failures = 0;

  bit m_act[NB];
  int m_x[NB], m_y[NB], m_dx[NB], m_dy[NB];
  int mdiv, hx, hy;

  bullet_pool #(.NB(NB), .RADIUS(5), .DIV(DIV), .HIT(8), .H_ACT(640), .V_ACT(480)) dut (
    .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .aactive(aactive),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .heart_x(heart_x), .heart_y(heart_y),
    .BulletSpriteOn(BulletSpriteOn), .hit(hit), .active_mask(active_mask)
  );

  always #5 Pclk = ~Pclk;

  // ---------------- reference model ----------------
  function automatic void m_clear();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
    end
    mdiv = 0;
  endfunction

  function automatic bit m_free();
    for (int i = 0; i < NB; i++) if (!m_act[i]) return 1;
    return 0;
  endfunction

  function automatic void m_spawn(int x, int y, int dx, int dy);
    for (int i = 0; i < NB; i++)
      if (!m_act[i]) begin
        m_act[i] = 1; m_x[i] = x; m_y[i] = y; m_dx[i] = dx; m_dy[i] = dy;
        return;
      end
  endfunction

  // Returns a bitmask of the slots that struck the heart
  function automatic int m_update();
    int r = 0;
    for (int i = 0; i < NB; i++)
      if (m_act[i]) begin
        int nx = m_x[i] + m_dx[i];
        int ny = m_y[i] + m_dy[i];
        int ax = (nx > hx) ? nx - hx : hx - nx;
        int ay = (ny > hy) ? ny - hy : hy - ny;
        if (nx < 0 || nx > 639 || ny < 0 || ny > 479) m_act[i] = 0;
        else if (ax <= 8 && ay <= 8) begin m_act[i] = 0; r |= (1 << i); end
        else begin m_x[i] = nx; m_y[i] = ny; end
      end
    return r;
  endfunction

  function automatic int m_mask();
    int r = 0;
    for (int i = 0; i < NB; i++) if (m_act[i]) r |= (1 << i);
    return r;
  endfunction

  function automatic bit m_pix(int px, int py);
    for (int i = 0; i < NB; i++)
      if (m_act[i] && ((px-m_x[i])*(px-m_x[i]) + (py-m_y[i])*(py-m_y[i]) <= 25)) return 1;
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge Pclk); #1; end
  endtask

  task automatic set_heart(input int x, input int y);
    hx = x; hy = y; heart_x = 10'(x); heart_y = 10'(y);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; xx = '0; yy = '0; aactive = 1'b0; spawn_valid = 1'b0;
    set_heart(600, 400);
    #2;
    m_clear();
    @(posedge Pclk); #1;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic spawn(input int x, input int y, input int dx, input int dy);
    bit er = m_free();
    checks++;
    if (spawn_ready !== er) begin
      failures++;
      $display("FAIL spawn_ready: got %b expected %b", spawn_ready, er);
    end
    spawn_x = 10'(x); spawn_y = 10'(y); spawn_dx = 4'(dx); spawn_dy = 4'(dy);
    spawn_valid = 1'b1;
    cyc(1);
    spawn_valid = 1'b0;
    if (er) m_spawn(x, y, dx, dy);
    checks++;
    if (active_mask !== NB'(m_mask())) begin
      failures++;
      $display("FAIL spawn_mask: got %b expected %b", active_mask, NB'(m_mask()));
    end
  endtask

  // One frame-end cycle (optionally with a simultaneous spawn from the spawn_* fields),
  // then NB cycles watching hit, which should match the slots the model saw strike.
  task automatic frame_end(input bit sp);
    int exp_hits = 0;
    int got = 0;
    bit wrap;
    xx = 10'd639; yy = 10'd479; aactive = 1'b0;
    if (sp) spawn_valid = 1'b1;
    cyc(1);
    xx = '0; yy = '0;
    if (sp) begin
      spawn_valid = 1'b0;
      m_spawn(int'(spawn_x), int'(spawn_y), int'($signed(spawn_dx)), int'($signed(spawn_dy)));
    end
    wrap = (mdiv == DIV-1);
    mdiv = wrap ? 0 : mdiv + 1;
    if (wrap) exp_hits = m_update();
    for (int k = 0; k < NB; k++) begin
      cyc(1);
      if (hit === 1'b1) got |= (1 << k);
      else if (hit !== 1'b0) got |= 256;
    end
    checks++;
    if (got !== exp_hits) begin
      failures++;
      $display("FAIL hit_pulses: got %0h expected %0h", got, exp_hits);
    end
    checks++;
    if (active_mask !== NB'(m_mask())) begin
      failures++;
      $display("FAIL update_mask: got %b expected %b", active_mask, NB'(m_mask()));
    end
  endtask

  task automatic probe(input int px, input int py, input bit a);
    bit e = a && m_pix(px, py);
    xx = 10'(px); yy = 10'(py); aactive = a;
    cyc(1);
    checks++;
    if (BulletSpriteOn !== e) begin
      failures++;
      $display("FAIL pixel(%0d,%0d,a=%0b): got %b expected %b", px, py, a, BulletSpriteOn, e);
    end
    xx = '0; yy = '0; aactive = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; xx = '0; yy = '0; aactive = 1'b0; spawn_valid = 1'b0;
    spawn_x = '0; spawn_y = '0; spawn_dx = '0; spawn_dy = '0;
    set_heart(600, 400);
    m_clear();
    cyc(2);
    checks++;
    if (active_mask !== '0) begin
      failures++; $display("FAIL reset_mask: got %b expected 0", active_mask);
    end
    check_bit("reset_bso", BulletSpriteOn, 1'b0);
    check_bit("reset_hit", hit, 1'b0);
    check_bit("reset_ready", spawn_ready, 1'b0);
    rst_n = 1'b1;
    check_bit("ready_first_cycle", spawn_ready, 1'b0);
    cyc(1);
    check_bit("ready_second_cycle", spawn_ready, 1'b1);
  endtask

  task automatic test_move();
    do_reset();
    spawn(300, 250, -2, 0);
    frame_end(0); frame_end(0);
    probe(298, 250, 1); probe(304, 250, 1);
    frame_end(0); frame_end(0);
    probe(296, 250, 1); probe(302, 250, 1); probe(296, 250, 0);
  endtask

  task automatic test_full();
    do_reset();
    spawn(100, 100, 0, 0); spawn(200, 100, 0, 0);
    spawn(3, 200, -8, 0);  spawn(300, 100, 0, 0);
    check_bit("full_ready", spawn_ready, 1'b0);
    spawn_x = 10'd50; spawn_y = 10'd50; spawn_dx = 4'hf; spawn_dy = 4'h0;
    spawn_valid = 1'b1;
    frame_end(0); frame_end(0);
    checks++;
    if (active_mask !== 4'b1011) begin
      failures++; $display("FAIL slot2_freed: got %b expected 1011", active_mask);
    end
    check_bit("refill_ready", spawn_ready, 1'b1);
    cyc(1);
    spawn_valid = 1'b0;
    m_spawn(50, 50, -1, 0);
    checks++;
    if (active_mask !== 4'b1111) begin
      failures++; $display("FAIL refill_mask: got %b expected 1111", active_mask);
    end
    probe(50, 50, 1);
    frame_end(0); frame_end(0);
    probe(49, 50, 1); probe(55, 50, 1);
  endtask

  task automatic test_exit();
    do_reset();
    spawn(1, 100, -2, 0);
    frame_end(0); frame_end(0);
  endtask

  task automatic test_hit();
    do_reset();
    set_heart(320, 240);
    spawn(330, 240, -4, 0);
    frame_end(0); frame_end(0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_heart(320, 240);
    spawn(330, 240, -4, 0); spawn(310, 240, 4, 0); spawn(100, 100, 1, 1);
    frame_end(0); frame_end(0);
  endtask

  task automatic test_pixel_edge();
    do_reset();
    spawn(3, 3, 0, 0);
    probe(0, 0, 1); probe(1023, 3, 1); probe(3, 1023, 1); probe(3, 3, 0);
    spawn(1020, 3, 0, 0);
    probe(1023, 3, 1); probe(0, 3, 1); probe(1023, 9, 1);
  endtask

  task automatic test_simul();
    do_reset();
    spawn(100, 100, 1, 0);
    frame_end(0);
    spawn_x = 10'd200; spawn_y = 10'd200; spawn_dx = 4'd3; spawn_dy = 4'd0;
    check_bit("simul_ready", spawn_ready, 1'b1);
    frame_end(1);
    probe(203, 200, 1); probe(101, 100, 1); probe(197, 200, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    spawn(100, 100, 1, 0); spawn(200, 200, 1, 0);
    frame_end(0);
    xx = 10'd639; yy = 10'd479;
    cyc(1);
    xx = '0; yy = '0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (active_mask !== '0) begin
      failures++; $display("FAIL midreset_mask: got %b expected 0", active_mask);
    end
    m_clear();
    @(posedge Pclk); #1;
    rst_n = 1'b1;
    check_bit("midreset_ready_first", spawn_ready, 1'b0);
    cyc(1);
    check_bit("midreset_ready_second", spawn_ready, 1'b1);
    frame_end(0); frame_end(0);
  endtask

  task automatic test_random();
    do_reset();
    set_heart($urandom_range(20, 620), $urandom_range(20, 460));
    for (int it = 0; it < 150; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 4) begin
        spawn($urandom_range(0, 700), $urandom_range(0, 520),
              int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      end else if (r < 6) begin
        frame_end(0);
      end else if (r == 9 && m_free()) begin
        spawn_x = 10'($urandom_range(0, 639)); spawn_y = 10'($urandom_range(0, 479));
        spawn_dx = 4'($urandom_range(0, 15)); spawn_dy = 4'($urandom_range(0, 15));
        frame_end(1);
      end else begin
        int j = $urandom_range(0, NB-1);
        int px = m_x[j] + int'($urandom_range(0, 12)) - 6;
        int py = m_y[j] + int'($urandom_range(0, 12)) - 6;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        if (px == 639 && py == 479) py = 478;
        probe(px, py, $urandom_range(0, 3) != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_full();
    test_exit();
    test_hit();
    test_back_to_back();
    test_pixel_edge();
    test_simul();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
